limd_arbiter: RTL and testbench

LIMD_ARBITER -- requirements
Module: limd_arbiter

---
 rtl/limd_arbiter_pkg.sv | 33 +++
 rtl/limd_arbiter_limd.sv | 39 +++
 rtl/limd_arbiter.sv | 136 +++++++++++++
 tb/tb_limd_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/limd_arbiter_pkg.sv
// Shared constants, FSM encoding and limiter arithmetic for the LIMD arbiter.
package limd_arbiter_pkg;

  localparam int unsigned W_DEF = 16;
  localparam logic [31:0] OME   = 32'd15360;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Values live in the low w bits; bit w-1 is the sign when judging ranges.
  function automatic logic [31:0] limd_a1p(input logic [31:0] a1t,
                                           input logic [31:0] a2p,
                                           input int unsigned w);
    logic [31:0] mask;
    logic [31:0] sgn;
    logic [31:0] ul;
    logic [31:0] ll;
    logic [31:0] t;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sgn  = 32'd1 << (w - 1);
    t    = a1t & mask;
    ul   = (OME - a2p) & mask;
    ll   = (a2p - OME) & mask;
    if (t >= sgn && t <= ll) return ll;
    if (t >= ul && t <= (sgn - 32'd1)) return ul;
    return t;
  endfunction

endpackage

// File: rtl/limd_arbiter_limd.sv
// LIMD limiter datapath: combinational a1 limiting from registered operands.
module limd_arbiter_limd
  import limd_arbiter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         scan_in0,
  input  logic         scan_in1,
  input  logic         scan_in2,
  input  logic         scan_in3,
  input  logic         scan_in4,
  input  logic         scan_enable,
  input  logic         test_mode,
  input  logic [W-1:0] a1t,
  input  logic [W-1:0] a2p,
  output logic [W-1:0] a1p,
  output logic         scan_out0,
  output logic         scan_out1,
  output logic         scan_out2,
  output logic         scan_out3,
  output logic         scan_out4
);

  // Clock, reset and scan only exist here for the DFT stitch.
  logic unused_dft;
  assign unused_dft = ^{clk, reset, scan_in0, scan_in1, scan_in2, scan_in3,
                        scan_in4, scan_enable, test_mode};

  assign a1p = W'(limd_a1p(32'(a1t), 32'(a2p), W));

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

endmodule

// File: rtl/limd_arbiter.sv
// Round-robin arbiter time-sharing one LIMD limiter among NCH channels.
//   state   | meaning
//   IDLE    | no service in flight, waiting for any req
//   ISSUE   | latched operands drive the limiter
//   CAPTURE | limiter result registered into a1p_out
//   DONE    | ack pulse for the winner, re-arbitrate with winner masked
module limd_arbiter
  import limd_arbiter_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_in0,
  input  logic             scan_in1,
  input  logic             scan_in2,
  input  logic             scan_in3,
  input  logic             scan_in4,
  input  logic             scan_enable,
  input  logic             test_mode,
  output logic             scan_out0,
  output logic             scan_out1,
  output logic             scan_out2,
  output logic             scan_out3,
  output logic             scan_out4,
  input  logic [NCH-1:0]   req,
  input  logic [NCH*W-1:0] a1t_in,
  input  logic [NCH*W-1:0] a2p_in,
  output logic [NCH-1:0]   ack,
  output logic [W-1:0]     a1p_out,
  output logic             busy
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  cur_ch;
  logic [CW-1:0]  pick;
  logic [CW-1:0]  idx;
  logic [NCH-1:0] masked;
  logic           found;
  logic           load;
  logic [W-1:0]   a1t_q;
  logic [W-1:0]   a2p_q;
  logic [W-1:0]   a1p_q;
  logic [W-1:0]   lim_a1p;

  // cur_ch doubles as last-served: search begins one past it and wraps.
  always_comb begin
    masked = req;
    if (state == ST_DONE) masked[cur_ch] = 1'b0;
    found = 1'b0;
    pick  = cur_ch;
    idx   = cur_ch;
    for (int i = 1; i <= NCH; i++) begin
      idx = CW'((int'(cur_ch) + i) % NCH);
      if (!found && masked[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          load     = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_nx = ST_CAPTURE;
      ST_CAPTURE: state_nx = ST_DONE;
      ST_DONE: begin
        if (found) begin
          load     = 1'b1;
          state_nx = ST_ISSUE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cur_ch  <= CW'(NCH - 1);
      a1t_q   <= '0;
      a2p_q   <= '0;
      a1p_q   <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        cur_ch <= pick;
        a1t_q  <= a1t_in[int'(pick)*W +: W];
        a2p_q  <= a2p_in[int'(pick)*W +: W];
      end
      if (state == ST_CAPTURE) a1p_q <= lim_a1p;
    end
  end

  limd_arbiter_limd #(.W(W)) u_limd (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (scan_in0),
    .scan_in1    (scan_in1),
    .scan_in2    (scan_in2),
    .scan_in3    (scan_in3),
    .scan_in4    (scan_in4),
    .scan_enable (scan_enable),
    .test_mode   (test_mode),
    .a1t         (a1t_q),
    .a2p         (a2p_q),
    .a1p         (lim_a1p),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4)
  );

  always_comb begin
    ack = '0;
    if (state == ST_DONE) ack[cur_ch] = 1'b1;
  end

  assign busy    = (state != ST_IDLE);
  assign a1p_out = a1p_q;

endmodule

// File: tb/tb_limd_arbiter.sv
// Scoreboard bench for limd_arbiter: directed scenarios plus randomized traffic.
module tb_limd_arbiter;
  import limd_arbiter_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       scan_in = '0;
  logic             scan_enable = 1'b0;
  logic             test_mode = 1'b0;
  logic [4:0]       scan_out;
  logic [NCH-1:0]   req = '0;
  logic [W-1:0]     a1t_v [NCH];
  logic [W-1:0]     a2p_v [NCH];
  logic [NCH*W-1:0] a1t_in;
  logic [NCH*W-1:0] a2p_in;
  logic [NCH-1:0]   ack;
  logic [W-1:0]     a1p_out;
  logic             busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          ch;
    logic [15:0] a1p;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   free_at = 0;
  int   last = NCH - 1;
  int   serving = -1;
  logic busy_exp = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    a1t_in = '0;
    a2p_in = '0;
    for (int i = 0; i < NCH; i++) begin
      a1t_in[i*W +: W] = a1t_v[i];
      a2p_in[i*W +: W] = a2p_v[i];
    end
  end

  limd_arbiter #(.NCH(NCH), .W(W)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .scan_in0    (scan_in[0]),
    .scan_in1    (scan_in[1]),
    .scan_in2    (scan_in[2]),
    .scan_in3    (scan_in[3]),
    .scan_in4    (scan_in[4]),
    .scan_enable (scan_enable),
    .test_mode   (test_mode),
    .scan_out0   (scan_out[0]),
    .scan_out1   (scan_out[1]),
    .scan_out2   (scan_out[2]),
    .scan_out3   (scan_out[3]),
    .scan_out4   (scan_out[4]),
    .req         (req),
    .a1t_in      (a1t_in),
    .a2p_in      (a2p_in),
    .ack         (ack),
    .a1p_out     (a1p_out),
    .busy        (busy)
  );

  function automatic logic [15:0] ref_lim(input logic [15:0] a1t, input logic [15:0] a2p);
    logic [15:0] ul;
    logic [15:0] ll;
    ul = 16'(OME) - a2p;
    ll = a2p - 16'(OME);
    if (a1t >= 16'h8000 && a1t <= ll) return ll;
    if (a1t >= ul && a1t <= 16'h7FFF) return ul;
    return a1t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req_v);
    end
  endtask

  // Reference: one server, fixed 3-cycle service, round-robin from last grant,
  // the channel just acked is ignored on the re-arbitration edge.
  always @(posedge clk) begin : model
    int ex;
    int pick;
    int c;
    cyc = cyc + 1;
    if (!rst_n) begin
      sb.delete();
      free_at  = 0;
      last     = NCH - 1;
      serving  = -1;
      busy_exp = 1'b0;
    end else if (cyc >= free_at) begin
      ex = (serving >= 0 && cyc == free_at) ? serving : -1;
      serving = -1;
      pick = -1;
      for (int k = 1; k <= NCH; k++) begin
        c = (last + k) % NCH;
        if (pick < 0 && req[2'(c)] && c != ex) pick = c;
      end
      if (pick >= 0) begin
        last    = pick;
        serving = pick;
        free_at = cyc + 3;
        sb.push_back('{pick, ref_lim(a1t_v[pick], a2p_v[pick]), cyc + 2});
      end
      busy_exp = (cyc < free_at);
    end else begin
      busy_exp = 1'b1;
    end
  end

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    check("scan_out", 32'(scan_out), 32'd0);
    if (!rst_n) begin
      check("reset_outputs", 32'({ack, a1p_out, busy}), 32'd0);
    end else begin
      check("busy", 32'(busy), 32'(busy_exp));
      if (ack != '0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ack actual=0x%0h required=no ack at cycle %0d", ack, cyc);
        end else begin
          e = sb.pop_front();
          check("ack_channel", 32'(ack), 32'd1 << e.ch);
          check("ack_cycle", 32'(cyc), 32'(e.edge_n));
          check("a1p_out", 32'(a1p_out), 32'(e.a1p));
        end
      end else if (sb.size() > 0 && sb[0].edge_n <= cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_ack actual=none required=ack[%0d] at cycle %0d", e.ch, e.edge_n);
      end
    end
  end

  task automatic wait_ack(output int ch, output int n);
    ch = -1;
    n  = 0;
    while (ch < 0 && n < 20) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NCH; i++) if (ack[2'(i)]) ch = i;
    end
    if (ch < 0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=none required=ack within 20 cycles");
    end
  endtask

  task automatic serve(input int chn, input int lat, input logic [15:0] a1p_req, input string tag);
    int ch;
    int n;
    wait_ack(ch, n);
    check({tag, "_channel"}, 32'(ch), 32'(chn));
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_a1p"}, 32'(a1p_out), 32'(a1p_req));
    if (ch >= 0) req[2'(ch)] = 1'b0;
  endtask

  task automatic random_phase(input int ncyc);
    logic [15:0] base;
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      scan_in     = 5'($urandom);
      scan_enable = 1'($urandom);
      test_mode   = 1'($urandom);
      for (int i = 0; i < NCH; i++) begin
        if (ack[2'(i)]) begin
          if ($urandom_range(3) != 0) req[2'(i)] = 1'b0;
        end else if (!req[2'(i)]) begin
          if ($urandom_range(3) == 0) req[2'(i)] = 1'b1;
        end else if ($urandom_range(39) == 0) begin
          req[2'(i)] = 1'b0;
        end
        if ($urandom_range(1) == 1) begin
          a2p_v[i] = 16'($urandom);
          case ($urandom_range(3))
            0: base = a2p_v[i] - 16'(OME);
            1: base = 16'(OME) - a2p_v[i];
            default: base = 16'($urandom);
          endcase
          a1t_v[i] = base + 16'($urandom_range(4)) - 16'd2;
        end
      end
    end
    scan_in     = '0;
    scan_enable = 1'b0;
    test_mode   = 1'b0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < NCH; i++) begin
      a1t_v[i] = '0;
      a2p_v[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    a1t_v[0] = 16'h9000; a2p_v[0] = 16'h0000; req[0] = 1'b1;
    serve(0, 3, 16'hC400, "neg_limit");
    @(negedge clk);
    a1t_v[1] = 16'h5000; a2p_v[1] = 16'h0000; req[1] = 1'b1;
    serve(1, 3, 16'h3C00, "pos_limit");
    @(negedge clk);
    a1t_v[1] = 16'h1000; req[1] = 1'b1;
    serve(1, 3, 16'h1000, "pass_through");
    @(negedge clk);

    // Operand change after latch must not leak into the result.
    a1t_v[0] = 16'h9000; a2p_v[0] = 16'h0000; req[0] = 1'b1;
    @(negedge clk);
    a1t_v[0] = 16'h1000;
    serve(0, 2, 16'hC400, "late_change");

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      a1t_v[i] = 16'($urandom);
      a2p_v[i] = 16'($urandom);
    end
    req = 4'b1111;
    for (int k = 0; k < NCH; k++) serve(k, 3, ref_lim(a1t_v[k], a2p_v[k]), "all_req");

    @(negedge clk);
    req[3] = 1'b1;
    req[0] = 1'b1;
    serve(0, 3, ref_lim(a1t_v[0], a2p_v[0]), "wrap_first");
    serve(3, 3, ref_lim(a1t_v[3], a2p_v[3]), "wrap_second");

    @(negedge clk);
    a1t_v[2] = 16'h9000; a2p_v[2] = 16'h0100; req[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_capture", 32'({ack, a1p_out, busy}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    serve(2, 3, 16'hC500, "after_reset");

    random_phase(600);

    req = '0;
    t = 0;
    while ((sb.size() > 0 || busy_exp) && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
